// File: rtl/ber_window_accumulator.sv
// BER measurement back-end: counts tested words, error bits and errored words
// over a programmable window, with a sticky threshold alarm.
module ber_window_accumulator #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] window_len,
  input  logic [CW-1:0] threshold,
  input  logic          err_valid,
  input  logic [W-1:0]  error,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] words_tested,
  output logic [CW-1:0] err_bits,
  output logic [CW-1:0] err_words,
  output logic          ber_exceeded
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] thr_q, thr_d;
  logic [CW-1:0] words_d, bits_d, ewords_d;
  logic          ber_d, busy_d, done_d;

  // Counters clamp at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CW] ? '1 : s[CW-1:0];
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [W-1:0] m);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + CW'(m[i]);
    return c;
  endfunction

  // Next-state and next-value logic
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    thr_d    = thr_q;
    words_d  = words_tested;
    bits_d   = err_bits;
    ewords_d = err_words;
    ber_d    = ber_exceeded;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          len_d    = window_len;
          thr_d    = threshold;
          words_d  = '0;
          bits_d   = '0;
          ewords_d = '0;
          ber_d    = 1'b0;
          state_d  = (window_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (err_valid) begin
          words_d  = sat_add(words_tested, CW'(1));
          bits_d   = sat_add(err_bits, popcount(error));
          ewords_d = sat_add(err_words, CW'(error != '0));
          if (bits_d > thr_q) ber_d = 1'b1;
          if (words_d == len_q) state_d = DONE;
        end
        // Abort overrides completion; the last word above is still counted.
        if (abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and result registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      thr_q        <= '0;
      words_tested <= '0;
      err_bits     <= '0;
      err_words    <= '0;
      ber_exceeded <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      thr_q        <= thr_d;
      words_tested <= words_d;
      err_bits     <= bits_d;
      err_words    <= ewords_d;
      ber_exceeded <= ber_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

endmodule

// File: tb/tb_ber_window_accumulator.sv
// Directed scoreboard bench for ber_window_accumulator.
module tb_ber_window_accumulator;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          start, abort, err_valid;
  logic [CW-1:0] window_len, threshold;
  logic [W-1:0]  error;
  logic          busy, done, ber_exceeded;
  logic [CW-1:0] words_tested, err_bits, err_words;

  ber_window_accumulator #(.W(W), .CW(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .window_len  (window_len),
    .threshold   (threshold),
    .err_valid   (err_valid),
    .error       (error),
    .busy        (busy),
    .done        (done),
    .words_tested(words_tested),
    .err_bits    (err_bits),
    .err_words   (err_words),
    .ber_exceeded(ber_exceeded)
  );

  always #5 clock = ~clock;

  typedef struct {
    string         tag;
    logic          busy;
    logic          done;
    logic [CW-1:0] words;
    logic [CW-1:0] bits;
    logic [CW-1:0] ewords;
    logic          ber;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  logic          m_busy, m_done, m_ber;
  logic [CW-1:0] m_len, m_thr, m_words, m_bits, m_ewords;

  task automatic cmp(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag; e.busy = m_busy; e.done = m_done; e.words = m_words;
    e.bits = m_bits; e.ewords = m_ewords; e.ber = m_ber;
    q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = q.pop_front();
    cmp({e.tag, ".busy"},   CW'(busy),         CW'(e.busy));
    cmp({e.tag, ".done"},   CW'(done),         CW'(e.done));
    cmp({e.tag, ".words"},  words_tested,      e.words);
    cmp({e.tag, ".bits"},   err_bits,          e.bits);
    cmp({e.tag, ".ewords"}, err_words,         e.ewords);
    cmp({e.tag, ".ber"},    CW'(ber_exceeded), CW'(e.ber));
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_ber = 0;
    m_len = '0; m_thr = '0; m_words = '0; m_bits = '0; m_ewords = '0;
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // One clock with the given inputs; model predicts, DUT result checked after edge.
  task automatic step(input string tag, input logic s, input logic a,
                      input logic [CW-1:0] len, input logic [CW-1:0] thr,
                      input logic v, input logic [W-1:0] e);
    logic fin;
    start = s; abort = a; window_len = len; threshold = thr; err_valid = v; error = e;
    if (!m_busy) begin
      if (s) begin
        m_len = len; m_thr = thr; m_words = '0; m_bits = '0; m_ewords = '0;
        m_ber = 0; m_done = (len == '0); m_busy = (len != '0);
      end
    end else begin
      fin = 0;
      if (v) begin
        m_words  = m_words + 1;
        m_bits   = m_bits + CW'($countones(e));
        m_ewords = m_ewords + CW'(e != '0);
        if (m_bits > m_thr) m_ber = 1;
        fin = (m_words == m_len);
      end
      if (a) begin
        m_busy = 0; m_done = 0;
      end else if (fin) begin
        m_busy = 0; m_done = 1;
      end
    end
    push_exp(tag);
    cycle();
    pop_check();
    start = 0; abort = 0; err_valid = 0; error = '0;
  endtask

  task automatic word(input string tag, input logic v, input logic [W-1:0] e);
    step(tag, 1'b0, 1'b0, window_len, threshold, v, e);
  endtask

  logic [W-1:0] s1_words [4];
  logic         s3_valid [8];

  initial begin
    s1_words = '{8'h00, 8'h01, 8'hFF, 8'h80};
    s3_valid = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    start = 0; abort = 0; err_valid = 0; error = '0;
    window_len = '0; threshold = '0;
    reset = 1;
    model_reset();
    cycle(); cycle();
    push_exp("reset");
    pop_check();
    reset = 0;

    // 1: basic window, no alarm
    step("s1_start", 1, 0, 32'd4, 32'd100, 0, '0);
    foreach (s1_words[i]) word($sformatf("s1_w%0d", i), 1'b1, s1_words[i]);
    word("s1_hold", 1'b1, 8'hFF);

    // 2: alarm rises after third word
    step("s2_start", 1, 0, 32'd4, 32'd8, 0, '0);
    foreach (s1_words[i]) word($sformatf("s2_w%0d", i), 1'b1, s1_words[i]);

    // 3: gapped valid stream
    step("s3_start", 1, 0, 32'd5, 32'd1000, 0, '0);
    foreach (s3_valid[i]) word($sformatf("s3_c%0d", i), s3_valid[i], 8'h03);

    // 4: zero-length window
    step("s4_start", 1, 0, 32'd0, 32'd0, 0, '0);
    word("s4_idle", 1'b1, 8'hFF);

    // 5: abort mid-window, then restart clears; threshold 0 alarms on first bit
    step("s5_start", 1, 0, 32'd10, 32'd100, 0, '0);
    for (int i = 0; i < 3; i++) word($sformatf("s5_w%0d", i), 1'b1, 8'h0F);
    step("s5_abort", 0, 1, window_len, threshold, 0, '0);
    word("s5_held", 1'b1, 8'hFF);
    step("s5_abort_idle", 0, 1, window_len, threshold, 0, '0);
    step("s5_restart", 1, 0, 32'd2, 32'd0, 0, '0);
    word("s5_thr0", 1'b1, 8'h01);
    step("s5_start_in_run", 1, 0, 32'd7, 32'd50, 0, '0);
    word("s5_complete", 1'b1, 8'h00);

    // abort together with the final word: counted, but no done
    step("s5b_start", 1, 0, 32'd2, 32'd100, 0, '0);
    word("s5b_w0", 1'b1, 8'h01);
    step("s5b_abort_last", 0, 1, window_len, threshold, 1, 8'h03);

    // start with abort in IDLE: start wins
    step("s5c_start_abort", 1, 1, 32'd3, 32'd100, 0, '0);
    step("s5c_abort_run", 1, 1, 32'd3, 32'd100, 1, 8'h01);

    // 6: asynchronous reset between edges
    step("s6_start", 1, 0, 32'd10, 32'd1, 0, '0);
    word("s6_w0", 1'b1, 8'h07);
    word("s6_w1", 1'b1, 8'h01);
    #3;
    reset = 1;
    #1;
    model_reset();
    push_exp("s6_async_reset");
    pop_check();
    cycle();
    reset = 0;
    word("s6_after", 1'b1, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
